sync_fifo_flags: RTL and testbench
==================================

Name: sync_fifo_flags

Overview:
- Single-clock parametrised FIFO; the single-clock counterpart to the dual-clock FIFO in the synchronizer library.
- Used where producer and consumer share a clock domain.
- Adds to the dual-clock FIFO: occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags, and an optional first-word-fall-through read mode.

Parameters:
- WIDTH, 8, data word width in bits (>=1).
- DEPTH, 8, number of entries; power of two, >=2.
- AF_THRESH, DEPTH-2, almost_full asserts when count >= AF_THRESH (1..DEPTH).
- AE_THRESH, 1, almost_empty asserts when count <= AE_THRESH (0..DEPTH-1).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- winc  input  1  write request.
- w_data  input  WIDTH  write data, sampled on an accepted write.
- rinc  input  1  read request.
- r_data  output  WIDTH  read data.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- almost_full  output  1  count >= AF_THRESH.
- almost_empty  output  1  count <= AE_THRESH.
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  output  1  sticky: a write was attempted while full.
- underflow  output  1  sticky: a read was attempted while empty.
- err_clr  input  1  synchronous clear of overflow/underflow.

Behaviour:
- Reset (rst=1, asynchronous, takes effect immediately):
  - wptr=0, rptr=0, count=0, r_data=0.
  - overflow=0, underflow=0.
  - empty=1, full=0, almost_full=0, almost_empty=1.
  - Memory contents are not reset.
- Status flags:
  - Derived combinationally from the registered count only; no path from winc/rinc to any flag.
  - Flags update the cycle after the causing edge.
- Write acceptance: wr_ok = winc & ~full, evaluated on pre-edge state.
  - On wr_ok: mem[wptr] <= w_data; wptr <= wptr+1 mod DEPTH.
- Read acceptance: rd_ok = rinc & ~empty, evaluated on pre-edge state.
  - On rd_ok: rptr <= rptr+1 mod DEPTH.
- Count update: +1 on wr_ok only; -1 on rd_ok only; unchanged when both or neither.
- Simultaneous winc & rinc:
  - When full: the read is accepted and the write is rejected (full is checked pre-edge); count becomes DEPTH-1; overflow sets.
  - When empty: the write is accepted and the read is rejected; count becomes 1; underflow sets.
  - Otherwise both are accepted and count is unchanged.
- Pointers are $clog2(DEPTH) bits and wrap naturally; full and empty are distinguished by count, not by pointer compare.
- Errors:
  - overflow <= 1 on winc & full; underflow <= 1 on rinc & empty.
  - Rejected operations do not change pointers, memory, count or r_data.
  - err_clr=1 clears both flags at the next edge.
  - err_clr has priority over a set in the same cycle, so the flag is 0 after that edge.
- Read latency (default mode): on rd_ok, r_data <= mem[rptr]; data is valid one cycle after the accepting edge. r_data holds its value otherwise.
- Reset mid-operation: all stored words are discarded and the FIFO reads as empty immediately. Writes are accepted from the first edge after rst deasserts.

Optional Feature:
- Macro: SYNC_FIFO_FWFT_EN.
- Defined (first-word-fall-through):
  - r_data = mem[rptr] combinationally whenever empty=0, so the head word is visible before the read.
  - rinc pops the head word; the next word appears after that edge.
  - r_data is don't-care while empty=1.
  - A word written into an empty FIFO appears on r_data the cycle after the write edge.
- Undefined: registered one-cycle read latency as above; r_data reset to 0.
- Flag, count and error behaviour are identical in both modes.

Test Plan (WIDTH=8, DEPTH=8, AF_THRESH=6, AE_THRESH=1):
- Reset, then 8 writes of 0x01..0x08:
  - count steps 1..8.
  - almost_empty drops once count becomes 2.
  - almost_full rises once count becomes 6.
  - full=1 after the 8th write; overflow stays 0.
- Full, then winc with w_data=0xAA for one cycle: overflow=1, count stays 8, memory unchanged.
  - Then err_clr pulse: overflow=0.
- Full, then 8 reads:
  - Default mode: r_data yields 0x01..0x08 each one cycle after its rinc edge.
  - Then empty=1, count=0.
  - One extra rinc: underflow=1, r_data holds 0x08.
- Pointer wrap: 12 writes interleaved with 12 reads (never more than 8 outstanding) -> read order is 1..12 with no loss across the wrap from address 7 to 0.
- Simultaneous winc & rinc edge cases:
  - For 20 cycles at count=3: count stays 3 and data order is preserved.
  - At count=8: count becomes 7 and overflow=1.
  - At count=0: count becomes 1, underflow=1, and the written word is read back next.
- Mid-stream reset with count=5 -> asynchronous rst asserts empty=1, count=0, r_data=0 immediately; with SYNC_FIFO_FWFT_EN, a write of 0x55 after release appears on r_data one cycle later with no rinc.

Source files
------------

// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags: single-clock FIFO with occupancy count, almost-full /
// almost-empty thresholds and sticky overflow/underflow error flags.
// Optional feature macro: SYNC_FIFO_FWFT_EN selects first-word-fall-through
// reads. Without it, r_data is registered with one cycle of read latency.
// Full and empty come from the occupancy count, not from a pointer compare,
// so the pointers need no extra wrap bit.

module sync_fifo_flags #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 8,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       winc,
  input  logic [WIDTH-1:0]           w_data,
  input  logic                       rinc,
  output logic [WIDTH-1:0]           r_data,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow,
  input  logic                       err_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             wr_ok;
  logic             rd_ok;

  // Flags depend only on the registered count, so winc/rinc never reach them.
  assign full         = (count == DEPTH_C);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_C);
  assign almost_empty = (count <= AE_C);

  // Acceptance uses the pre-edge flags: a full FIFO rejects writes even if a
  // read happens in the same cycle, and an empty FIFO rejects reads likewise.
  assign wr_ok = winc & ~full;
  assign rd_ok = rinc & ~empty;

  // Storage array; deliberately left without reset.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wptr] <= w_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr_ok) begin
        wptr <= wptr + 1'b1;
      end
      if (rd_ok) begin
        rptr <= rptr + 1'b1;
      end
      if (wr_ok && !rd_ok) begin
        count <= count + 1'b1;
      end else if (rd_ok && !wr_ok) begin
        count <= count - 1'b1;
      end
    end
  end

  // Sticky error flags; a clear wins over a set in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (err_clr) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (winc && full) begin
        overflow <= 1'b1;
      end
      if (rinc && empty) begin
        underflow <= 1'b1;
      end
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  // The head word is always presented; its value is meaningless while empty.
  assign r_data = mem[rptr];
`else
  // Registered read port: the popped word is valid the cycle after the pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data <= '0;
    end else if (rd_ok) begin
      r_data <= mem[rptr];
    end
  end
`endif

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Self-checking bench for sync_fifo_flags (WIDTH=8, DEPTH=8, AF=6, AE=1).
// A queue-based reference model runs alongside the DUT and is compared on
// every falling edge. Directed steps add literal expectations on top of it.

module tb_sync_fifo_flags;

  localparam int WIDTH = 8;
  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int AE    = 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             winc = 1'b0;
  logic [WIDTH-1:0] w_data = '0;
  logic             rinc = 1'b0;
  logic             err_clr = 1'b0;
  logic [WIDTH-1:0] r_data;
  logic             full, empty, almost_full, almost_empty;
  logic [3:0]       count;
  logic             overflow, underflow;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  logic [WIDTH-1:0] q[$];
  logic             m_ovf = 1'b0;
  logic             m_udf = 1'b0;
  logic [WIDTH-1:0] m_rdata = '0;

  sync_fifo_flags #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE)
  ) dut (
    .clk(clk), .rst(rst), .winc(winc), .w_data(w_data), .rinc(rinc),
    .r_data(r_data), .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .count(count), .overflow(overflow),
    .underflow(underflow), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // model update: decisions use the occupancy before the edge
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      m_ovf   = 1'b0;
      m_udf   = 1'b0;
      m_rdata = '0;
    end else begin
      bit was_full, was_empty;
      was_full  = (q.size() == DEPTH);
      was_empty = (q.size() == 0);
      if (rinc && !was_empty) m_rdata = q.pop_front();
      if (winc && !was_full)  q.push_back(w_data);
      if (err_clr) begin
        m_ovf = 1'b0;
        m_udf = 1'b0;
      end else begin
        if (winc && was_full)  m_ovf = 1'b1;
        if (rinc && was_empty) m_udf = 1'b1;
      end
    end
  end

  // compare process, away from the active edge
  always @(negedge clk) begin
    chk("count", 32'(count), 32'(q.size()));
    chk("full", 32'(full), 32'(q.size() == DEPTH));
    chk("empty", 32'(empty), 32'(q.size() == 0));
    chk("almost_full", 32'(almost_full), 32'(q.size() >= AF));
    chk("almost_empty", 32'(almost_empty), 32'(q.size() <= AE));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("underflow", 32'(underflow), 32'(m_udf));
`ifdef SYNC_FIFO_FWFT_EN
    if (q.size() != 0) chk("r_data_head", 32'(r_data), 32'(q[0]));
`else
    chk("r_data", 32'(r_data), 32'(m_rdata));
`endif
  end

  task automatic step(input logic w, input logic [WIDTH-1:0] d, input logic r, input logic ec);
    @(negedge clk);
    #1;
    winc = w; w_data = d; rinc = r; err_clr = ec;
    @(posedge clk);
    #2;
    winc = 1'b0; rinc = 1'b0; err_clr = 1'b0;
  endtask

  task automatic read_expect(input string name, input logic [WIDTH-1:0] v);
`ifdef SYNC_FIFO_FWFT_EN
    chk(name, 32'(r_data), 32'(v));
    step(1'b0, '0, 1'b1, 1'b0);
`else
    step(1'b0, '0, 1'b1, 1'b0);
    chk(name, 32'(r_data), 32'(v));
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, n_checks=%0d", n_checks);
    $fatal(1);
  end

  initial begin
    int wp;
    #1 rst = 1'b1;
    #1;
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_ae", 32'(almost_empty), 1);
    chk("rst_af", 32'(almost_full), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_udf", 32'(underflow), 0);
`ifndef SYNC_FIFO_FWFT_EN
    chk("rst_rdata", 32'(r_data), 0);
`endif
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;

    // fill with 0x01..0x08
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, WIDTH'(i), 1'b0, 1'b0);
      chk("fill_count", 32'(count), 32'(i));
      chk("fill_ae", 32'(almost_empty), 32'(i <= 1));
      chk("fill_af", 32'(almost_full), 32'(i >= 6));
      chk("fill_full", 32'(full), 32'(i == 8));
      chk("fill_ovf", 32'(overflow), 0);
    end

    // write while full
    step(1'b1, 8'hAA, 1'b0, 1'b0);
    chk("ovf_set", 32'(overflow), 1);
    chk("ovf_count", 32'(count), 8);
    step(1'b0, '0, 1'b0, 1'b1);
    chk("ovf_clr", 32'(overflow), 0);

    // drain 0x01..0x08, then one read too many
    for (int i = 1; i <= 8; i++) read_expect("drain_data", WIDTH'(i));
    chk("drain_empty", 32'(empty), 1);
    chk("drain_count", 32'(count), 0);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("udf_set", 32'(underflow), 1);
`ifndef SYNC_FIFO_FWFT_EN
    chk("udf_rdata_hold", 32'(r_data), 8'h08);
`endif
    step(1'b0, '0, 1'b0, 1'b1);
    chk("udf_clr", 32'(underflow), 0);

    // pointer wrap: write/read interleaved across address 7 -> 0
    for (int i = 1; i <= 12; i++) begin
      step(1'b1, WIDTH'(8'h10 + i), 1'b0, 1'b0);
      read_expect("wrap_data", WIDTH'(8'h10 + i));
    end

    // simultaneous read/write at count=3
    for (int i = 0; i < 3; i++) step(1'b1, WIDTH'(8'h21 + i), 1'b0, 1'b0);
    for (int k = 0; k < 20; k++) begin
      logic [WIDTH-1:0] ev;
      ev = (k < 3) ? WIDTH'(8'h21 + k) : WIDTH'(8'h30 + k - 3);
`ifdef SYNC_FIFO_FWFT_EN
      chk("both3_data", 32'(r_data), 32'(ev));
      step(1'b1, WIDTH'(8'h30 + k), 1'b1, 1'b0);
`else
      step(1'b1, WIDTH'(8'h30 + k), 1'b1, 1'b0);
      chk("both3_data", 32'(r_data), 32'(ev));
`endif
      chk("both3_count", 32'(count), 3);
    end
    for (int k = 17; k < 20; k++) read_expect("both3_tail", WIDTH'(8'h30 + k));

    // simultaneous at full
    for (int i = 0; i < 8; i++) step(1'b1, WIDTH'(8'h40 + i), 1'b0, 1'b0);
    read_expect("bothfull_data", 8'h40);
    chk("bothfull_count_pre", 32'(count), 7);
    for (int i = 0; i < 1; i++) step(1'b1, 8'h48, 1'b0, 1'b0);
    chk("refull_count", 32'(count), 8);
`ifdef SYNC_FIFO_FWFT_EN
    chk("bothfull_head", 32'(r_data), 8'h41);
`endif
    step(1'b1, 8'h99, 1'b1, 1'b0);
    chk("bothfull_count", 32'(count), 7);
    chk("bothfull_ovf", 32'(overflow), 1);
`ifndef SYNC_FIFO_FWFT_EN
    chk("bothfull_rdata", 32'(r_data), 8'h41);
`endif
    step(1'b0, '0, 1'b0, 1'b1);
    for (int i = 2; i <= 8; i++) read_expect("bothfull_drain", WIDTH'(8'h40 + i));

    // simultaneous at empty
    chk("bothempty_pre", 32'(count), 0);
    step(1'b1, 8'h77, 1'b1, 1'b0);
    chk("bothempty_count", 32'(count), 1);
    chk("bothempty_udf", 32'(underflow), 1);
    read_expect("bothempty_data", 8'h77);
    step(1'b0, '0, 1'b0, 1'b1);

    // mid-stream asynchronous reset at count=5
    for (int i = 0; i < 5; i++) step(1'b1, WIDTH'(8'h60 + i), 1'b0, 1'b0);
    chk("mid_count_pre", 32'(count), 5);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_empty", 32'(empty), 1);
    chk("mid_rst_count", 32'(count), 0);
`ifndef SYNC_FIFO_FWFT_EN
    chk("mid_rst_rdata", 32'(r_data), 0);
`endif
    @(negedge clk);
    #1 rst = 1'b0;
    step(1'b1, 8'h55, 1'b0, 1'b0);
    chk("post_rst_count", 32'(count), 1);
`ifdef SYNC_FIFO_FWFT_EN
    chk("post_rst_fwft", 32'(r_data), 8'h55);
`endif
    read_expect("post_rst_data", 8'h55);

    // randomized traffic with varying fill bias
    wp = 50;
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) begin
        case ($urandom_range(0, 2))
          0: wp = 20;
          1: wp = 50;
          default: wp = 80;
        endcase
      end
      @(negedge clk);
      #1;
      winc    = ($urandom_range(0, 99) < wp);
      rinc    = ($urandom_range(0, 99) < (100 - wp));
      w_data  = WIDTH'($urandom);
      err_clr = ($urandom_range(0, 31) == 0);
    end
    @(negedge clk);
    #1;
    winc = 1'b0; rinc = 1'b0; err_clr = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
